// File: rtl/iq_demod_dump.sv
// Lock-in I/Q demodulator: multiplies samples by the DDS sin/cos references, integrates over
// 2^n_log2 valid samples and dumps the mean. Define IQ_DEMOD_SAT_EN to saturate the outputs.
module iq_demod_dump #(
    parameter int DATA_W     = 16,
    parameter int LOG2_N_MAX = 16,
    parameter int ACC_W      = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [4:0]               n_log2,
    input  logic                     sync_in,
    input  logic                     sig_valid,
    input  logic signed [DATA_W-1:0] sig_in,
    input  logic signed [DATA_W-1:0] sin_ref,
    input  logic signed [DATA_W-1:0] cos_ref,
    output logic signed [DATA_W-1:0] i_out,
    output logic signed [DATA_W-1:0] q_out,
    output logic                     out_valid,
    output logic                     busy
);
    // state | meaning
    // IDLE  | disabled, everything cleared
    // ARM   | enabled, waiting for the DDS phase-wrap pulse
    // ACCUM | integrating windows back to back
    typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;

    localparam int PW    = 2 * DATA_W;
    localparam int CNT_W = LOG2_N_MAX;

    state_t                  state;
    logic [4:0]              n_q;
    logic [4:0]              n_clamp;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    win_first;
    logic                    win_last;

    logic                    v1, first1, last1, done2;
    logic [4:0]              n1, n2;
    logic signed [PW-1:0]    prod_i, prod_q;
    logic signed [ACC_W-1:0] acc_i, acc_q;

    // Down-counter reload value: samples remaining in the window minus one.
    function automatic logic [CNT_W-1:0] tc_load(input logic [4:0] n);
        logic [CNT_W:0] w;
        w = (CNT_W+1)'(1) << n;
        return CNT_W'(w - (CNT_W+1)'(1));
    endfunction

    function automatic logic signed [DATA_W-1:0] to_out(input logic signed [ACC_W-1:0] v);
`ifdef IQ_DEMOD_SAT_EN
        if (v[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){v[ACC_W-1]}})
            return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return v[DATA_W-1:0];
`else
        return DATA_W'(v);
`endif
    endfunction

    always_comb begin
        n_clamp = n_log2;
        if (32'(n_log2) > LOG2_N_MAX)
            n_clamp = 5'(LOG2_N_MAX);
    end

    assign accept    = en && sig_valid && (state == ACCUM || (state == ARM && sync_in));
    assign win_first = (cnt == tc_load(n_q));
    assign win_last  = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            n_q   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            n_q   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARM;
                    n_q   <= n_clamp;
                    cnt   <= tc_load(n_clamp);
                end
                ARM: begin
                    if (sync_in) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: ;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (accept) begin
                if (win_last) begin
                    n_q <= n_clamp;
                    cnt <= tc_load(n_clamp);
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    // Three-stage datapath: product, accumulate, scale/dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            first1    <= 1'b0;
            last1     <= 1'b0;
            n1        <= '0;
            prod_i    <= '0;
            prod_q    <= '0;
            done2     <= 1'b0;
            n2        <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
        end else if (!en) begin
            v1        <= 1'b0;
            done2     <= 1'b0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            v1     <= accept;
            first1 <= win_first;
            last1  <= win_last;
            n1     <= n_q;
            if (accept) begin
                prod_i <= PW'(sig_in) * PW'(sin_ref);
                prod_q <= PW'(sig_in) * PW'(cos_ref);
            end
            done2 <= v1 && last1;
            n2    <= n1;
            if (v1) begin
                acc_i <= first1 ? ACC_W'(prod_i) : acc_i + ACC_W'(prod_i);
                acc_q <= first1 ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
            end
            out_valid <= done2;
            if (done2) begin
                i_out <= to_out((acc_i >>> n2) >>> (DATA_W-1));
                q_out <= to_out((acc_q >>> n2) >>> (DATA_W-1));
            end
        end
    end
endmodule

// File: tb/tb_iq_demod_dump.sv
// Self-checking bench for iq_demod_dump: directed window table, hand-written corner
// sequences and a randomized run checked against a window-level arithmetic model.
module tb_iq_demod_dump;
    logic               clk = 1'b0;
    logic               rst, en, sync_in, sig_valid;
    logic [4:0]         n_log2;
    logic signed [15:0] sig_in, sin_ref, cos_ref, i_out, q_out;
    logic               out_valid, busy;

    iq_demod_dump dut (
        .clk(clk), .rst(rst), .en(en), .n_log2(n_log2), .sync_in(sync_in),
        .sig_valid(sig_valid), .sig_in(sig_in), .sin_ref(sin_ref), .cos_ref(cos_ref),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef IQ_DEMOD_SAT_EN
    localparam int SAT_POS = 32767;
`else
    localparam int SAT_POS = -32768;
`endif
    localparam int NR = 300;

    typedef struct {
        string name;
        int    n;
        int    sig;
        int    sn;
        int    cs;
        bit    gaps;
        int    exp_i;
        int    exp_q;
    } vec_t;
    typedef struct { int c; int i; int q; } ev_t;

    vec_t vecs[6];
    ev_t  ev_q[$];
    ev_t  exp_ev[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   r_v[NR], r_s[NR], r_n[NR], r_sig[NR], r_sin[NR], r_cos[NR];

    always @(negedge clk)
        if (out_valid) ev_q.push_back('{cyc, int'(i_out), int'(q_out)});

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int k);
        sig_valid = 1'b0;
        sync_in   = 1'b0;
        repeat (k) tick();
    endtask

    task automatic sample(input int s, input int sn, input int cs, input bit sy);
        sig_valid = 1'b1;
        sync_in   = sy;
        sig_in    = 16'(s);
        sin_ref   = 16'(sn);
        cos_ref   = 16'(cs);
        tick();
    endtask

    task automatic start(input int n);
        en = 1'b0;
        idle(1);
        en = 1'b1;
        n_log2 = 5'(n);
        idle(1);
    endtask

    // Window mean: floor(sum / 2^(n + 15)), then fitted to 16 bits.
    function automatic int expect_mean(input longint sum, input int n);
        longint v;
        logic signed [15:0] t;
        v = sum >>> (n + 15);
`ifdef IQ_DEMOD_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        t = 16'(v);
`else
        t = 16'(v);
`endif
        return int'(t);
    endfunction

    initial begin
        int cnt_s, last_c, cur_n, wcnt;
        int sc[12];
        longint si, sq;
        logic signed [15:0] tmp;

        vecs[0] = '{"avg_half",  2,  16384,  16384,      0, 1'b0,    8192,      0};
        vecs[1] = '{"gap_floor", 3,  -8192,      0,  32767, 1'b1,       0,  -8192};
        vecs[2] = '{"corner",    0, -32768, -32768,      0, 1'b0, SAT_POS,      0};
        vecs[3] = '{"fullscale", 1,  32767, -32768,  32767, 1'b1,  -32767,  32766};
        vecs[4] = '{"tiny_neg",  4,     -1,      1,     -1, 1'b1,      -1,      0};
        vecs[5] = '{"clamp17",  17,  32767,  32767, -32768, 1'b0,   32766, -32767};

        rst = 1'b0; en = 1'b0; sync_in = 1'b0; sig_valid = 1'b0; n_log2 = '0;
        sig_in = '0; sin_ref = '0; cos_ref = '0;
        tick(); tick();
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        foreach (vecs[v]) begin
            cnt_s = 1 << ((vecs[v].n > 16) ? 16 : vecs[v].n);
            start(vecs[v].n);
            check({vecs[v].name, "_busy_arm"}, busy, 0);
            ev_q.delete();
            for (int k = 0; k < cnt_s; k++) begin
                if (vecs[v].gaps && k > 0) idle($urandom_range(0, 2));
                sample(vecs[v].sig, vecs[v].sn, vecs[v].cs, k == 0);
                if (k == 0) check({vecs[v].name, "_busy_accum"}, busy, 1);
            end
            last_c = cyc;
            idle(5);
            check({vecs[v].name, "_pulses"}, ev_q.size(), 1);
            if (ev_q.size() > 0) begin
                check({vecs[v].name, "_latency"}, ev_q[0].c, last_c + 2);
                check({vecs[v].name, "_i"}, ev_q[0].i, vecs[v].exp_i);
                check({vecs[v].name, "_q"}, ev_q[0].q, vecs[v].exp_q);
            end
        end

        // Back-to-back windows; n_log2 wiggled mid-window must not shorten window 0.
        start(2);
        ev_q.delete();
        for (int k = 0; k < 12; k++) begin
            n_log2 = (k == 1 || k == 2) ? 5'd0 : 5'd2;
            sample(1000 * (k + 1), 16384, -16384, k == 0);
            sc[k] = cyc;
        end
        idle(5);
        check("b2b_pulses", ev_q.size(), 3);
        for (int w = 0; w < 3; w++) begin
            si = 0;
            for (int j = 0; j < 4; j++) si += longint'(1000 * (4 * w + j + 1)) * 16384;
            if (w < ev_q.size()) begin
                check("b2b_latency", ev_q[w].c, sc[4 * w + 3] + 2);
                check("b2b_i", ev_q[w].i, expect_mean(si, 2));
                check("b2b_q", ev_q[w].q, expect_mean(-si, 2));
            end
        end

        // en dropped mid-window, then re-enabled without sync.
        start(2);
        ev_q.delete();
        sample(16384, 16384, 16384, 1'b1);
        sample(16384, 16384, 16384, 1'b0);
        en = 1'b0;
        idle(3);
        check("endrop_pulses", ev_q.size(), 0);
        check("endrop_hold_i", i_out, 5250);
        check("endrop_hold_q", q_out, -5250);
        en = 1'b1;
        idle(1);
        for (int k = 0; k < 6; k++) sample(16384, 16384, 16384, 1'b0);
        idle(4);
        check("nosync_pulses", ev_q.size(), 0);
        ev_q.delete();
        for (int k = 0; k < 4; k++) sample(16384, 16384, 16384, k == 0);
        idle(4);
        check("resync_pulses", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check("resync_i", ev_q[0].i, 8192);
            check("resync_q", ev_q[0].q, 8192);
        end

        // Asynchronous reset in the middle of a window.
        start(2);
        sample(16384, 16384, 16384, 1'b1);
        sample(16384, 16384, 16384, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_i_out", i_out, 0);
        check("arst_q_out", q_out, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        idle(2);
        rst = 1'b1;
        ev_q.delete();
        idle(1);
        for (int k = 0; k < 6; k++) sample(16384, 16384, 16384, 1'b0);
        idle(4);
        check("arst_nosync_pulses", ev_q.size(), 0);
        for (int k = 0; k < 4; k++) sample(-16384, 16384, -16384, k == 0);
        idle(4);
        check("arst_fresh_pulses", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check("arst_fresh_i", ev_q[0].i, -8192);
            check("arst_fresh_q", ev_q[0].q, 8192);
        end

        // Randomized run against the window-level model.
        en = 1'b0;
        idle(1);
        ev_q.delete();
        last_c = cyc;
        for (int t = 0; t < NR; t++) begin
            r_v[t] = (t >= 1) ? int'($urandom_range(0, 3) != 0) : 0;
            r_s[t] = (t == 6) ? 1 : ((t > 6) ? int'($urandom_range(0, 9) == 0) : 0);
            r_n[t] = $urandom_range(0, 3);
            tmp = 16'($urandom); r_sig[t] = tmp;
            tmp = 16'($urandom); r_sin[t] = tmp;
            tmp = 16'($urandom); r_cos[t] = tmp;
            en = 1'b1;
            sig_valid = r_v[t][0];
            sync_in = r_s[t][0];
            n_log2 = 5'(r_n[t]);
            sig_in = 16'(r_sig[t]);
            sin_ref = 16'(r_sin[t]);
            cos_ref = 16'(r_cos[t]);
            tick();
        end
        idle(5);
        exp_ev.delete();
        cur_n = r_n[0];
        wcnt = 0; si = 0; sq = 0;
        for (int t = 6; t < NR; t++) begin
            if (r_v[t] != 0) begin
                si += longint'(r_sig[t]) * longint'(r_sin[t]);
                sq += longint'(r_sig[t]) * longint'(r_cos[t]);
                wcnt++;
                if (wcnt == (1 << cur_n)) begin
                    exp_ev.push_back('{last_c + t + 3, expect_mean(si, cur_n), expect_mean(sq, cur_n)});
                    wcnt = 0; si = 0; sq = 0;
                    cur_n = r_n[t];
                end
            end
        end
        check("rand_pulses", ev_q.size(), exp_ev.size());
        for (int k = 0; k < exp_ev.size() && k < ev_q.size(); k++) begin
            check("rand_cycle", ev_q[k].c, exp_ev[k].c);
            check("rand_i", ev_q[k].i, exp_ev[k].i);
            check("rand_q", ev_q[k].q, exp_ev[k].q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/iq_demod_dump.md
Name: iq_demod_dump

Overview:
- Lock-in receive side of the DDS reference path.
- Multiplies an incoming signed sample stream by the DDS sine/cosine references.
- Integrates each product over a window of 2^n_log2 valid samples, then dumps normalised I/Q means.
- Sits between the ADC sample stream and the lock-in servo logic; synchronised to the DDS phase-wrap pulse.

Parameters:
- DATA_W, 16, width of signed sample and reference inputs.
- LOG2_N_MAX, 16, largest supported window exponent.
- ACC_W, 48, accumulator width (2*DATA_W + LOG2_N_MAX).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  block enable; low forces IDLE and clears the accumulators.
- n_log2  in  5  window exponent; values above LOG2_N_MAX clamp to LOG2_N_MAX.
- sync_in  in  1  DDS phase-wrap pulse; arms window alignment.
- sig_valid  in  1  sample qualifier.
- sig_in  in  DATA_W  signed input sample.
- sin_ref  in  DATA_W  signed DDS sine, aligned with sig_in.
- cos_ref  in  DATA_W  signed DDS cosine, aligned with sig_in.
- i_out  out  DATA_W  signed in-phase mean.
- q_out  out  DATA_W  signed quadrature mean.
- out_valid  out  1  one-cycle pulse when i_out/q_out update.
- busy  out  1  high in ACCUM.

Behaviour:
- Reset (rst=0, async): state IDLE; i_out=0, q_out=0, out_valid=0, busy=0; accumulators, sample counter and pipeline registers cleared.
- IDLE: go to ARM when en=1.
- ARM: on sync_in=1 go to ACCUM. A sync_in cycle that also has sig_valid=1 counts that sample as sample 0.
- ACCUM: every cycle with sig_valid=1 accepts one sample and increments the counter.
  - n_log2 is latched (after clamping) when ARM is entered and at each window boundary. Changes mid-window are ignored.
  - After 2^n_log2 accepted samples the window closes.
  - The next window starts with the very next valid sample; no samples are dropped and there is no re-arm on sync_in.
- Pipeline, per accepted sample at cycle t:
  - t+1: full-precision signed products sig*sin and sig*cos registered (2*DATA_W bits).
  - t+2: products added to the ACC_W accumulators. A window's first product loads the accumulator instead of adding to it.
  - For the window's final sample, the final sum is captured at t+2; i_out/q_out are registered and out_valid pulses at t+3, exactly 3 cycles after the final sample is accepted.
- Arithmetic:
  - Result = (acc >>> n_log2) >>> (DATA_W-1), arithmetic shifts, truncation toward minus infinity.
  - Only case exceeding DATA_W: all products equal (-2^(DATA_W-1))^2, which yields +2^(DATA_W-1). Handling is defined under Optional Feature.
  - Accumulator cannot overflow for n_log2 ≤ LOG2_N_MAX.
- n_log2=0: every valid sample produces an out_valid, 3 cycles later.
- en deasserted in any state:
  - Next cycle: state IDLE, accumulators/counter cleared, in-flight pipeline contents discarded.
  - No out_valid for the partial window; i_out/q_out hold their last values.
  - Re-enable requires a new sync_in.
- sync_in during ACCUM: ignored.
- busy = 1 only in ACCUM.
- Outputs hold between out_valid pulses.

Optional Feature:
- Macro IQ_DEMOD_SAT_EN.
- Defined: i_out/q_out saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] after the shift; the +2^(DATA_W-1) case yields 32767 for DATA_W=16.
- Undefined: plain truncation to DATA_W bits; the +2^(DATA_W-1) case wraps to -32768.
- No other behaviour differs.

Test Plan:
- en=1, n_log2=2, sync_in then 4 consecutive valid samples sig=16384, sin=16384, cos=0 -> out_valid 3 cycles after 4th sample; i_out=8192, q_out=0; busy high during the window.
- n_log2=3, 8 valid samples spread with random sig_valid gaps, sig=-8192, sin=0, cos=32767 -> single out_valid 3 cycles after 8th valid sample; q_out=-8192 (floor of -8191.75); i_out=0.
- n_log2=0, sig=-32768, sin=-32768 on one sample -> i_out=32767 with IQ_DEMOD_SAT_EN, -32768 without.
- n_log2=2, 12 back-to-back samples -> exactly 3 out_valid pulses, 4 cycles apart, each with correct mean; change n_log2 mid-window has no effect until the next window.
- en dropped after 2 of 4 samples -> no out_valid, outputs hold prior values; re-enable with samples but no sync_in -> no out_valid; sync_in then 4 samples -> normal result.
- Assert rst=0 asynchronously mid-window -> outputs 0 immediately, state IDLE; after release behaves as fresh start (needs en and sync_in).
